// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle unsigned adder/subtractor.
// Each clock adds one CHUNK-bit slice, LSB slice first, through a full-adder
// ripple chain. The carry between slices is held in a register. Valid/ready
// handshakes on both sides.
// An operation accepted at edge T presents its result at edge T+NCHUNK. The
// result is held until out_ready, and the block returns to IDLE one cycle later.
// Optional: define CHUNKED_SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;
    logic             release_out;

    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic [CHUNK:0]   slice_res;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_co;

    // Full-adder ripple chain over one slice; returns {carry_out, sum}.
    function automatic logic [CHUNK:0] ripple(input logic [CHUNK-1:0] x,
                                              input logic [CHUNK-1:0] y,
                                              input logic             ci);
        logic             c;
        logic [CHUNK-1:0] s;
        c = ci;
        s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        return {c, s};
    endfunction

    assign in_ready = (state == IDLE);

    // Operand registers shift right each RUN cycle, so the active slice is always the low CHUNK bits.
    always_comb begin
        slice_res = ripple(a_reg[CHUNK-1:0], b_reg[CHUNK-1:0], carry);
        slice_sum = slice_res[CHUNK-1:0];
        slice_co  = slice_res[CHUNK];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        last        = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture operands on accept (B inverted and carry flipped for subtract), then walk the slices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_reg <= a_reg >> CHUNK;
            b_reg <= b_reg >> CHUNK;
            carry <= slice_co;
            cnt   <= cnt + 1'b1;
            for (int k = 0; k < NCHUNK; k++) begin
                if (cnt == CNT_W'(k)) begin
                    sum[k*CHUNK +: CHUNK] <= slice_sum;
                end
            end
            if (last) begin
                cout <= slice_co;
            end
        end
    end

    // Result valid: raised with the final slice, dropped on the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (last) begin
            out_valid <= 1'b1;
        end else if (release_out) begin
            out_valid <= 1'b0;
        end
    end

`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit: c = s ^ x ^ y.
    logic msb_cin;
    assign msb_cin = slice_sum[CHUNK-1] ^ a_reg[CHUNK-1] ^ b_reg[CHUNK-1];

    // Signed overflow, captured in the last RUN cycle alongside cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last) begin
            ovf <= msb_cin ^ slice_co;
        end
    end
`endif

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Testbench for chunked_serial_adder: table-driven vectors and hand-written
// sequences on the CHUNK=4 instance, with results checked through a scoreboard.
// Two further instances (CHUNK=16, CHUNK=1) are exercised in lockstep.
module tb_chunked_serial_adder;

    localparam int W       = 16;
    localparam int SPACING = 6;   // accept edge, 4 RUN edges, DONE handshake edge, then IDLE

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  a, b, sum;
    logic          cin, sub, cout;
    logic          iv16, ir16, ov16, co16;
    logic [W-1:0]  sum16;
    logic          iv1, ir1, ov1, co1;
    logic [W-1:0]  sum1;
    logic          ready_hi;
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
    logic          ovf, ovf16, ovf1;
`endif

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    chunked_serial_adder #(.WIDTH(W), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov16),
        .out_ready(ready_hi), .sum(sum16), .cout(co16)
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
        , .ovf(ovf16)
`endif
    );

    chunked_serial_adder #(.WIDTH(W), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov1),
        .out_ready(ready_hi), .sum(sum1), .cout(co1)
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        res_t         exp;
    } vec_t;

    res_t sb[$];
    res_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: integer arithmetic, with signed range test for overflow.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        logic [W:0] full;
        int         sv;
        res_t       r;
        if (!s) begin
            full = {1'b0, x} + {1'b0, y} + 17'(ci);
            sv   = int'($signed(x)) + int'($signed(y)) + int'(ci);
        end else begin
            full = {1'b0, x} + {1'b0, ~y} + 17'(!ci);
            sv   = int'($signed(x)) - int'($signed(y)) - int'(ci);
        end
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (sv > 32767) || (sv < -32768);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            check("sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("sum", 32'(sum), 32'(mon_e.sum));
                check("cout", 32'(cout), 32'(mon_e.cout));
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
                check("ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
            end
        end
    end

    task automatic wait_accept();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("accept_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    // One operation on the main instance with out_ready held high.
    task automatic do_op(input vec_t v);
        int lat;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
        wait_accept();
        sb.push_back(v.exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'(~v.a); b = 16'($urandom); cin = ~v.cin; sub = ~v.sub;
        check("in_ready_busy", 32'(in_ready), 32'd0);
        wait_out(lat);
        check("latency", 32'(lat), 32'd4);
        @(posedge clk); #1;
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
    endtask

    vec_t tbl[12];
    int   lat;
    int   prev_acc;
    bit   s16, s1;
    res_t e;

    initial begin
        // {a, b, cin, sub, {sum, cout, ovf}}
        tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}};
        tbl[1]  = '{16'h1234, 16'h0234, 1'b0, 1'b1, '{16'h1000, 1'b1, 1'b0}};
        tbl[2]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, '{16'hFFFF, 1'b0, 1'b0}};
        tbl[3]  = '{16'h0005, 16'h0003, 1'b1, 1'b1, '{16'h0001, 1'b1, 1'b0}};
        tbl[4]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0}};
        tbl[5]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
        tbl[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
        tbl[7]  = '{16'h0003, 16'h0004, 1'b0, 1'b0, '{16'h0007, 1'b0, 1'b0}};
        tbl[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0}};
        tbl[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};
        tbl[10] = '{16'h0000, 16'h0000, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0}};
        tbl[11] = '{16'h1234, 16'h4321, 1'b1, 1'b0, '{16'h5556, 1'b0, 1'b0}};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ready_hi = 1'b1;
        iv16 = 1'b0; iv1 = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #23;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Table-driven vectors
        for (int i = 0; i < 12; i++) do_op(tbl[i]);

        // Backpressure: result held 5 cycles, second request ignored until IDLE
        out_ready = 1'b0;
        a = 16'h1234; b = 16'h0234; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
        wait_accept();
        sb.push_back(res_t'{16'h1000, 1'b1, 1'b0});
        @(posedge clk); #1;
        a = 16'h0100; b = 16'h0023; cin = 1'b0; sub = 1'b0;
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum", 32'(sum), 32'h1000);
            check("bp_cout", 32'(cout), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle", 32'(in_ready), 32'd1);
        wait_accept();
        sb.push_back(res_t'{16'h0123, 1'b0, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        @(posedge clk); #1;

        // Asynchronous reset after two chunks
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        wait_accept();
        sb.push_back(res_t'{16'h3333, 1'b0, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_sb_cleared", 32'(sb.size()), 32'd0);
        do_op(tbl[4]);

        // Back-to-back random, in_valid and out_ready held high
        prev_acc = 0;
        in_valid = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            wait_accept();
            if (n > 0) check("b2b_spacing", 32'(cyc - prev_acc), 32'(SPACING));
            prev_acc = cyc;
            sb.push_back(model(a, b, cin, sub));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) break;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        // CHUNK=16 (latency 1) and CHUNK=1 (latency 16) in lockstep
        for (int n = 0; n < 100; n++) begin
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            e = model(a, b, cin, sub);
            iv16 = 1'b1; iv1 = 1'b1;
            @(negedge clk);
            check("x_ready", 32'(ir16 & ir1), 32'd1);
            @(posedge clk); #1;
            iv16 = 1'b0; iv1 = 1'b0;
            s16 = 1'b0; s1 = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                if (ov16 && !s16) begin
                    s16 = 1'b1;
                    check("lat16", 32'(c), 32'd1);
                    check("sum16", 32'(sum16), 32'(e.sum));
                    check("cout16", 32'(co16), 32'(e.cout));
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
                    check("ovf16", 32'(ovf16), 32'(e.ovf));
`endif
                end
                if (ov1 && !s1) begin
                    s1 = 1'b1;
                    check("lat1", 32'(c), 32'd16);
                    check("sum1", 32'(sum1), 32'(e.sum));
                    check("cout1", 32'(co1), 32'(e.cout));
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
                    check("ovf1", 32'(ovf1), 32'(e.ovf));
`endif
                end
                if (s16 && s1) break;
            end
            check("x_seen", 32'({s16, s1}), 32'd3);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
